// File: rtl/ftdi_245fifo_slave_if.sv
// Chip-side FTDI 245 sync FIFO bus plus the host-side AXI-stream pair.
// slave = the chip model, master = FPGA/host drivers.
interface ftdi_245fifo_slave_if #(
    parameter int CHIP_EW = 0
);
    localparam int DW = 8 << CHIP_EW;
    localparam int BW = 1 << CHIP_EW;

    logic          h2f_tvalid;
    logic          h2f_tready;
    logic [DW-1:0] h2f_tdata;
    logic [BW-1:0] h2f_tkeep;
    logic          f2h_tvalid;
    logic          f2h_tready;
    logic [DW-1:0] f2h_tdata;
    logic [BW-1:0] f2h_tkeep;
    logic          ftdi_rxf_n;
    logic          ftdi_txe_n;
    logic          ftdi_oe_n;
    logic          ftdi_rd_n;
    logic          ftdi_wr_n;
    logic          ftdi_slave_oe;
    logic [DW-1:0] ftdi_data_out;
    logic [BW-1:0] ftdi_be_out;
    logic [DW-1:0] ftdi_data_in;
    logic [BW-1:0] ftdi_be_in;
    logic          proto_err;

    modport slave (
        input  h2f_tvalid, h2f_tdata, h2f_tkeep, f2h_tready,
        input  ftdi_oe_n, ftdi_rd_n, ftdi_wr_n,
        input  ftdi_data_in, ftdi_be_in,
        output h2f_tready, f2h_tvalid, f2h_tdata, f2h_tkeep,
        output ftdi_rxf_n, ftdi_txe_n, ftdi_slave_oe,
        output ftdi_data_out, ftdi_be_out, proto_err
    );

    modport master (
        output h2f_tvalid, h2f_tdata, h2f_tkeep, f2h_tready,
        output ftdi_oe_n, ftdi_rd_n, ftdi_wr_n,
        output ftdi_data_in, ftdi_be_in,
        input  h2f_tready, f2h_tvalid, f2h_tdata, f2h_tkeep,
        input  ftdi_rxf_n, ftdi_txe_n, ftdi_slave_oe,
        input  ftdi_data_out, ftdi_be_out, proto_err
    );
endinterface

// File: rtl/ftdi_245fifo_slave.sv
// FTDI 245 synchronous FIFO chip model: two count-based FIFOs bridging
// the FPGA-facing strobe bus to host-side AXI-stream ports.
module ftdi_245fifo_slave #(
    parameter int CHIP_EW = 0,
    parameter int DEPTH_W = 4
) (
    input  logic clk,
    input  logic rstn,
    ftdi_245fifo_slave_if.slave bus
);
    localparam int DW    = 8 << CHIP_EW;
    localparam int BW    = 1 << CHIP_EW;
    localparam int EW    = DW + BW;
    localparam int DEPTH = 1 << DEPTH_W;
    localparam int CW    = DEPTH_W + 1;
    localparam logic [CW-1:0]      FULL = CW'(DEPTH);
    localparam logic [DEPTH_W-1:0] PINC = DEPTH_W'(1);

    logic [EW-1:0]      r_h2f_mem [DEPTH];
    logic [DEPTH_W-1:0] r_h2f_wp;
    logic [DEPTH_W-1:0] r_h2f_rp;
    logic [CW-1:0]      r_h2f_cnt;
    logic               r_rxf_n;
    logic               r_h2f_tready;
    logic               w_h2f_push;
    logic               w_h2f_pop;
    logic [CW-1:0]      w_h2f_cnt_nxt;
    logic [BW-1:0]      w_h2f_keep;
    logic [EW-1:0]      w_h2f_head;

    logic [EW-1:0]      r_f2h_mem [DEPTH];
    logic [DEPTH_W-1:0] r_f2h_wp;
    logic [DEPTH_W-1:0] r_f2h_rp;
    logic [CW-1:0]      r_f2h_cnt;
    logic               r_txe_n;
    logic               w_f2h_be_ok;
    logic               w_f2h_wr;
    logic               w_f2h_pop;
    logic               w_f2h_tvalid;
    logic [CW-1:0]      w_f2h_cnt_nxt;
    logic [EW-1:0]      w_f2h_tail;

    logic               r_proto_err;

    // Pops are gated by the registered RXF#, so a read strobe on an
    // empty FIFO (end of burst) is simply ignored.
    assign w_h2f_push    = bus.h2f_tvalid & r_h2f_tready;
    assign w_h2f_pop     = ~bus.ftdi_rd_n & ~bus.ftdi_oe_n & ~r_rxf_n;
    assign w_h2f_cnt_nxt = r_h2f_cnt + CW'(w_h2f_push) - CW'(w_h2f_pop);
    assign w_h2f_keep    = (CHIP_EW == 0) ? '1 : bus.h2f_tkeep;
    assign w_h2f_head    = r_h2f_mem[r_h2f_rp];

    // A write with no byte lanes enabled carries nothing and is dropped.
    assign w_f2h_be_ok   = (CHIP_EW == 0) || (|bus.ftdi_be_in);
    assign w_f2h_wr      = ~bus.ftdi_wr_n & ~r_txe_n & w_f2h_be_ok;
    assign w_f2h_tvalid  = (r_f2h_cnt != '0);
    assign w_f2h_pop     = w_f2h_tvalid & bus.f2h_tready;
    assign w_f2h_cnt_nxt = r_f2h_cnt + CW'(w_f2h_wr) - CW'(w_f2h_pop);
    assign w_f2h_tail    = r_f2h_mem[r_f2h_rp];

    assign bus.h2f_tready    = r_h2f_tready;
    assign bus.ftdi_rxf_n    = r_rxf_n;
    assign bus.ftdi_slave_oe = ~bus.ftdi_oe_n;
    assign bus.ftdi_data_out = w_h2f_head[EW-1:BW];
    assign bus.ftdi_be_out   = (CHIP_EW == 0) ? '1 : w_h2f_head[BW-1:0];

    assign bus.ftdi_txe_n    = r_txe_n;
    assign bus.f2h_tvalid    = w_f2h_tvalid;
    assign bus.f2h_tdata     = w_f2h_tail[EW-1:BW];
    assign bus.f2h_tkeep     = (CHIP_EW == 0) ? '1 : w_f2h_tail[BW-1:0];

    assign bus.proto_err     = r_proto_err;

    // h2f storage: written by the host, no reset needed on the array.
    always_ff @(posedge clk) begin
        if (w_h2f_push) begin
            r_h2f_mem[r_h2f_wp] <= {bus.h2f_tdata, w_h2f_keep};
        end
    end

    // h2f pointers, count and the registered RXF#/TREADY flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_h2f_wp     <= '0;
            r_h2f_rp     <= '0;
            r_h2f_cnt    <= '0;
            r_rxf_n      <= 1'b1;
            r_h2f_tready <= 1'b0;
        end else begin
            if (w_h2f_push) begin
                r_h2f_wp <= r_h2f_wp + PINC;
            end
            if (w_h2f_pop) begin
                r_h2f_rp <= r_h2f_rp + PINC;
            end
            r_h2f_cnt    <= w_h2f_cnt_nxt;
            r_rxf_n      <= (w_h2f_cnt_nxt == '0);
            r_h2f_tready <= (w_h2f_cnt_nxt != FULL);
        end
    end

    // f2h storage: written by the FPGA with its data and byte enables.
    always_ff @(posedge clk) begin
        if (w_f2h_wr) begin
            r_f2h_mem[r_f2h_wp] <= {bus.ftdi_data_in, bus.ftdi_be_in};
        end
    end

    // f2h pointers, count and the registered TXE# flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_f2h_wp  <= '0;
            r_f2h_rp  <= '0;
            r_f2h_cnt <= '0;
            r_txe_n   <= 1'b1;
        end else begin
            if (w_f2h_wr) begin
                r_f2h_wp <= r_f2h_wp + PINC;
            end
            if (w_f2h_pop) begin
                r_f2h_rp <= r_f2h_rp + PINC;
            end
            r_f2h_cnt <= w_f2h_cnt_nxt;
            r_txe_n   <= (w_f2h_cnt_nxt == FULL);
        end
    end

    // Sticky flag: read without OE#, or OE# and WR# low together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_proto_err <= 1'b0;
        end else if ((~bus.ftdi_rd_n & bus.ftdi_oe_n) |
                     (~bus.ftdi_oe_n & ~bus.ftdi_wr_n)) begin
            r_proto_err <= 1'b1;
        end
    end
endmodule

// File: doc/ftdi_245fifo_slave.md
Name: ftdi_245fifo_slave

Overview:
- Synthesizable model of the FTDI chip end of the 245 synchronous FIFO interface (FT232H/FT600/FT601 style).
- It drives RXF#/TXE#, answers OE#/RD#/WR# from the FPGA-side master, and bridges to host-side AXI-stream ports through two internal FIFOs.
- Used for on-chip loopback and for simulation benches of the FPGA-side master without a physical USB chip.

Parameters:
- CHIP_EW, 0: data width select; 0 = 8-bit, 1 = 16-bit, 2 = 32-bit. Data width DW = 8<<CHIP_EW, byte-enable width BW = 1<<CHIP_EW.
- DEPTH_W, 4: log2 of each internal FIFO depth. Each direction holds 2**DEPTH_W words.

Ports:
- rstn  in  1  asynchronous active-low reset
- clk  in  1  interface clock (CLKOUT of the chip); all logic on posedge
- h2f_tvalid  in  1  host word available for the FPGA
- h2f_tready  out  1  h2f FIFO not full
- h2f_tdata  in  DW  host data
- h2f_tkeep  in  BW  host byte enables; ignored when CHIP_EW=0
- f2h_tvalid  out  1  word written by the FPGA is available to the host
- f2h_tready  in  1  host accepts the word
- f2h_tdata  out  DW  FPGA-written data
- f2h_tkeep  out  BW  FPGA-written byte enables; all ones when CHIP_EW=0
- ftdi_rxf_n  out  1  low = data available for the FPGA to read
- ftdi_txe_n  out  1  low = space available for the FPGA to write
- ftdi_oe_n  in  1  FPGA output-enable request (chip drives the bus when low)
- ftdi_rd_n  in  1  FPGA read strobe
- ftdi_wr_n  in  1  FPGA write strobe
- ftdi_slave_oe  out  1  1 = chip drives DATA/BE
- ftdi_data_out  out  DW  h2f FIFO head word
- ftdi_be_out  out  BW  byte enables of the head word
- ftdi_data_in  in  DW  bus data driven by the FPGA
- ftdi_be_in  in  BW  bus byte enables driven by the FPGA
- proto_err  out  1  sticky protocol-violation flag

Behaviour:

Reset:
- h2f and f2h FIFOs are emptied; both counts = 0.
- rxf_n = 1, txe_n = 1, proto_err = 0, h2f_tready = 0, f2h_tvalid = 0.

h2f FIFO (host → chip → FPGA):
- Show-ahead FIFO with a registered count in 0..2**DEPTH_W.
- Host push: on posedge when h2f_tvalid & h2f_tready.
- FPGA pop: on posedge when ~rd_n & ~oe_n & ~rxf_n.
- Simultaneous push and pop: count unchanged, both operations take effect.
- h2f_tready = registered (count_next != 2**DEPTH_W).
- rxf_n = registered (count_next == 0). The cycle after the last word is popped, rxf_n = 1.
- ftdi_slave_oe = ~oe_n, combinational. The master asserts OE# one cycle before RD#, which gives the bus turnaround.
- ftdi_data_out / ftdi_be_out = head word, combinational from FIFO memory.
- When CHIP_EW=0, ftdi_be_out is all ones.
- rd_n low while rxf_n = 1: no pop and no error. This is the legal end-of-burst cycle.

f2h FIFO (FPGA → chip → host):
- FPGA write accepted on posedge when ~wr_n & ~txe_n; stores {ftdi_data_in, ftdi_be_in}.
- When CHIP_EW>0, a write with ftdi_be_in == 0 is discarded and the count is unchanged.
- txe_n = registered (count_next == 2**DEPTH_W).
- At the first posedge after reset release, txe_n falls to 0.
- wr_n low while txe_n = 1: no write and no error.
- Host side: f2h_tvalid = (count != 0); pop on f2h_tvalid & f2h_tready.
- Simultaneous write and host pop: count unchanged.

Pointers:
- Pointers are DEPTH_W bits and wrap modulo 2**DEPTH_W.
- Full/empty is derived from the count, never from pointer equality.

proto_err:
- Set on posedge when ~rd_n & oe_n (read without output enable).
- Set on posedge when ~oe_n & ~wr_n (bus contention).
- Cleared only by reset.

Latency:
- Host push to rxf_n low: 1 cycle.
- FPGA write to f2h_tvalid high: 1 cycle.

Reset mid-burst: any in-flight data is lost; outputs return to their reset values immediately (asynchronous).

Test Plan:
- Reset then idle, DEPTH_W=4, CHIP_EW=0:
  - During rstn=0: rxf_n=1, txe_n=1.
  - One cycle after release: txe_n=0, rxf_n=1, h2f_tready=1, f2h_tvalid=0.
- Host pushes 0x11, 0x22, 0x33; master pulses OE# then holds RD# low:
  - rxf_n=0 one cycle after the first push.
  - Master samples 0x11, 0x22, 0x33 on consecutive posedges.
  - rxf_n=1 on the cycle after 0x33 is sampled.
  - One further RD#-low cycle causes no pop and proto_err stays 0.
- Host pushes 16 words with RD# idle:
  - h2f_tready=0 after the 16th push.
  - A 17th h2f_tvalid is not accepted.
  - Draining one word reasserts h2f_tready the next cycle.
- FPGA writes 16 words 0x00..0x0F with f2h_tready=0:
  - txe_n=1 after the 16th write; a 17th WR# pulse is ignored.
  - Host then reads 0x00..0x0F in order with f2h_tkeep all ones.
- CHIP_EW=1:
  - Write 0xABCD with BE=2'b01: stored with f2h_tkeep=01.
  - Write with BE=2'b00: dropped, f2h count unchanged.
- Protocol errors:
  - RD#=0 with OE#=1 → proto_err=1 next cycle and stays set.
  - A fresh reset with OE#=0 and WR#=0 simultaneously → proto_err=1.
- Reset mid-burst:
  - Assert rstn=0 with 5 words in each FIFO → rxf_n=1, f2h_tvalid=0, counts 0.
  - After release, no stale data appears on either side.
